// File: rtl/freq_meas_ctrl_if.sv
// Signal bundle between the measurement sequencer and its environment
// (board-level keys/display on one side, frequency-counter core on the other).
// The master modport is the sequencer itself; slave is whatever drives it.
interface freq_meas_ctrl_if;
  logic       iSTART;
  logic       iAUTO;
  logic       iMEAS_DONE;
  logic [3:0] iBCD3;
  logic [3:0] iBCD2;
  logic [3:0] iBCD1;
  logic [3:0] iBCD0;
  logic [1:0] iDEC;

  logic       oMEAS_START;
  logic [3:0] oBCD3;
  logic [3:0] oBCD2;
  logic [3:0] oBCD1;
  logic [3:0] oBCD0;
  logic [1:0] oDEC;
  logic       oVALID;
  logic       oBUSY;
  logic       oTIMEOUT;

  modport master (
    input  iSTART, iAUTO, iMEAS_DONE, iBCD3, iBCD2, iBCD1, iBCD0, iDEC,
    output oMEAS_START, oBCD3, oBCD2, oBCD1, oBCD0, oDEC, oVALID, oBUSY, oTIMEOUT
  );

  modport slave (
    output iSTART, iAUTO, iMEAS_DONE, iBCD3, iBCD2, iBCD1, iBCD0, iDEC,
    input  oMEAS_START, oBCD3, oBCD2, oBCD1, oBCD0, oDEC, oVALID, oBUSY, oTIMEOUT
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: issues one-cycle start commands to the frequency
// counter (one-shot on a key edge or periodically in auto mode), waits for the
// done pulse under a timeout, and holds the resulting BCD digits and range
// code stable for the display between measurements.
module freq_meas_ctrl #(
  parameter int REFRESH_CYCLES = 25_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int TW             = 27
) (
  input  logic             iCLK,
  input  logic             iRESET,
  freq_meas_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, HOLD} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          prev;
  logic          meas_start;
  logic          busy;
  logic          valid;
  logic          timeout;
  logic [3:0]    bcd3, bcd2, bcd1, bcd0;
  logic [1:0]    dec;

  logic          start_edge;
  logic          timeout_hit;
  logic          refresh_hit;

  // Rising edge of the start key, and terminal counts of the shared timer.
  assign start_edge  = bus.iSTART & ~prev;
  assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign refresh_hit = (timer == TW'(REFRESH_CYCLES - 1));

  // Sequencer FSM with all outputs and hold registers registered.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state      <= IDLE;
      timer      <= '0;
      // NOTE: prev resets to 1 so a key already held through reset reads as
      // "no edge" and cannot launch a measurement on release.
      prev       <= 1'b1;
      meas_start <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      bcd3       <= '0;
      bcd2       <= '0;
      bcd1       <= '0;
      bcd0       <= '0;
      dec        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state/timer/prev regardless of statement order.
      prev       <= bus.iSTART;
      meas_start <= 1'b0;

      case (state)
        IDLE: begin
          if (start_edge) begin
            state      <= ARM;
            meas_start <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ARM: begin
          state <= WAIT;
          timer <= '0;
        end

        WAIT: begin
          timer <= timer + TW'(1);
          if (bus.iMEAS_DONE) begin
            bcd3    <= bus.iBCD3;
            bcd2    <= bus.iBCD2;
            bcd1    <= bus.iBCD1;
            bcd0    <= bus.iBCD0;
            dec     <= bus.iDEC;
            valid   <= 1'b1;
            timeout <= 1'b0;
            busy    <= 1'b0;
            timer   <= '0;
            state   <= bus.iAUTO ? HOLD : IDLE;
          end else if (timeout_hit) begin
            bcd3    <= '0;
            bcd2    <= '0;
            bcd1    <= '0;
            bcd0    <= '0;
            dec     <= '0;
            valid   <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            timer   <= '0;
            state   <= bus.iAUTO ? HOLD : IDLE;
          end
        end

        HOLD: begin
          timer <= timer + TW'(1);
          if (!bus.iAUTO) begin
            state <= IDLE;
          end else if (start_edge || refresh_hit) begin
            state      <= ARM;
            meas_start <= 1'b1;
            busy       <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Drive the interface from the registered state.
  assign bus.oMEAS_START = meas_start;
  assign bus.oBUSY       = busy;
  assign bus.oVALID      = valid;
  assign bus.oTIMEOUT    = timeout;
  assign bus.oBCD3       = bcd3;
  assign bus.oBCD2       = bcd2;
  assign bus.oBCD1       = bcd1;
  assign bus.oBCD0       = bcd0;
  assign bus.oDEC        = dec;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl with REFRESH_CYCLES=8, TIMEOUT_CYCLES=20.
// Output vector layout used in comparisons:
//   [21] oMEAS_START [20] oBUSY [19] oVALID [18] oTIMEOUT
//   [17:2] oBCD3..oBCD0  [1:0] oDEC
module tb_freq_meas_ctrl;

  localparam int REFRESH = 8;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  freq_meas_ctrl_if bus ();

  freq_meas_ctrl #(
    .REFRESH_CYCLES (REFRESH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TW             (8)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] outs();
    return {bus.oMEAS_START, bus.oBUSY, bus.oVALID, bus.oTIMEOUT,
            bus.oBCD3, bus.oBCD2, bus.oBCD1, bus.oBCD0, bus.oDEC};
  endfunction

  function automatic logic [21:0] mk(logic ms, logic bsy, logic vld, logic tmo,
                                     logic [15:0] bcd, logic [1:0] dc);
    return {ms, bsy, vld, tmo, bcd, dc};
  endfunction

  task automatic set_result(logic [15:0] bcd, logic [1:0] dc);
    {bus.iBCD3, bus.iBCD2, bus.iBCD1, bus.iBCD0} = bcd;
    bus.iDEC = dc;
  endtask

  task automatic test_reset();
    logic [21:0] obs;
    rst = 1'b1;
    bus.iSTART = 1'b1;
    bus.iAUTO = 1'b0;
    bus.iMEAS_DONE = 1'b0;
    set_result(16'h0000, 2'd0);
    repeat (3) tick();
    obs = outs();
    n_total++;
    if (obs !== '0) $display("FAIL reset_state: got %h expected %h", obs, 22'h0);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      obs = outs();
      n_total++;
      if (obs !== '0) $display("FAIL reset_release_held_start[%0d]: got %h expected %h", i, obs, 22'h0);
      else n_pass++;
    end
    bus.iSTART = 1'b0;
    tick();
  endtask

  task automatic test_manual();
    logic [21:0] obs, exp;
    bus.iAUTO = 1'b0;
    bus.iSTART = 1'b1;
    tick();
    obs = outs(); exp = mk(1, 1, 0, 0, 16'h0000, 2'd0);
    n_total++;
    if (obs !== exp) $display("FAIL manual_arm: got %h expected %h", obs, exp);
    else n_pass++;
    bus.iSTART = 1'b0;
    tick();
    obs = outs(); exp = mk(0, 1, 0, 0, 16'h0000, 2'd0);
    n_total++;
    if (obs !== exp) $display("FAIL manual_wait_single_start: got %h expected %h", obs, exp);
    else n_pass++;
    tick();
    bus.iMEAS_DONE = 1'b1;
    set_result(16'h1234, 2'b10);
    tick();
    bus.iMEAS_DONE = 1'b0;
    set_result(16'hABCD, 2'b01);
    obs = outs(); exp = mk(0, 0, 1, 0, 16'h1234, 2'b10);
    n_total++;
    if (obs !== exp) $display("FAIL manual_result: got %h expected %h", obs, exp);
    else n_pass++;
    tick();
    obs = outs();
    n_total++;
    if (obs !== exp) $display("FAIL manual_idle_hold: got %h expected %h", obs, exp);
    else n_pass++;
    // Stray done pulse while idle must be ignored.
    bus.iMEAS_DONE = 1'b1;
    set_result(16'h9876, 2'b11);
    tick();
    bus.iMEAS_DONE = 1'b0;
    tick();
    obs = outs();
    n_total++;
    if (obs !== exp) $display("FAIL stray_done_idle: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [21:0] obs, exp;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      obs = outs(); exp = mk(0, 1, 1, 0, 16'h1234, 2'b10);
      n_total++;
      if (obs !== exp) $display("FAIL timeout_wait_cycle[%0d]: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
    tick();
    obs = outs(); exp = mk(0, 0, 0, 1, 16'h0000, 2'd0);
    n_total++;
    if (obs !== exp) $display("FAIL timeout_abort: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_coincide();
    logic [21:0] obs, exp;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    repeat (TIMEOUT) tick();
    bus.iMEAS_DONE = 1'b1;
    set_result(16'h9012, 2'b11);
    tick();
    bus.iMEAS_DONE = 1'b0;
    obs = outs(); exp = mk(0, 0, 1, 0, 16'h9012, 2'b11);
    n_total++;
    if (obs !== exp) $display("FAIL done_timeout_coincide: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_auto();
    logic [21:0] obs, exp;
    logic [1:0]  obs2, exp2;
    int          r, m, starts;
    bus.iAUTO = 1'b1;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    obs2 = {bus.oMEAS_START, bus.oBUSY};
    n_total++;
    if (obs2 !== 2'b11) $display("FAIL auto_first_start: got %b expected %b", obs2, 2'b11);
    else n_pass++;
    for (int c = 0; c < 35; c++) begin
      r = c / 12;
      bus.iMEAS_DONE = 1'b0;
      if (c % 12 == 3) begin
        bus.iMEAS_DONE = 1'b1;
        set_result({4'(r + 1), 4'(r + 2), 4'(r + 3), 4'(r + 4)}, 2'(r));
      end else if (c % 12 == 6) begin
        bus.iMEAS_DONE = 1'b1;
        set_result(16'hFFFF, 2'b11);
      end
      tick();
      m = (c + 1) % 12;
      obs2 = {bus.oMEAS_START, bus.oBUSY};
      exp2 = {(m == 0), (m <= 3)};
      n_total++;
      if (obs2 !== exp2) $display("FAIL auto_period_cycle[%0d]: got %b expected %b", c + 1, obs2, exp2);
      else n_pass++;
    end
    bus.iMEAS_DONE = 1'b0;
    obs = outs(); exp = mk(0, 0, 1, 0, 16'h3456, 2'd2);
    n_total++;
    if (obs !== exp) $display("FAIL auto_held_after_stray: got %h expected %h", obs, exp);
    else n_pass++;
    // Last HOLD cycle: dropping auto must beat refresh expiry.
    bus.iAUTO = 1'b0;
    starts = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.oMEAS_START === 1'b1) starts++;
    end
    n_total++;
    if (starts !== 0) $display("FAIL auto_drop_no_start: got %0d starts expected 0", starts);
    else n_pass++;
    obs = outs();
    n_total++;
    if (obs !== exp) $display("FAIL auto_drop_idle: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_ignored();
    logic [21:0] obs, exp;
    bus.iAUTO = 1'b1;
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    tick();
    bus.iSTART = 1'b1;
    tick();
    obs = outs(); exp = mk(0, 1, 1, 0, 16'h3456, 2'd2);
    n_total++;
    if (obs !== exp) $display("FAIL start_in_wait_ignored: got %h expected %h", obs, exp);
    else n_pass++;
    bus.iSTART = 1'b0;
    bus.iMEAS_DONE = 1'b1;
    set_result(16'h7777, 2'b01);
    tick();
    bus.iMEAS_DONE = 1'b0;
    obs = outs(); exp = mk(0, 0, 1, 0, 16'h7777, 2'b01);
    n_total++;
    if (obs !== exp) $display("FAIL hold_entry: got %h expected %h", obs, exp);
    else n_pass++;
    tick();
    bus.iSTART = 1'b1;
    tick();
    bus.iSTART = 1'b0;
    obs = outs(); exp = mk(1, 1, 1, 0, 16'h7777, 2'b01);
    n_total++;
    if (obs !== exp) $display("FAIL hold_retrigger: got %h expected %h", obs, exp);
    else n_pass++;
    tick();
    rst = 1'b1;
    #1;
    obs = outs();
    n_total++;
    if (obs !== '0) $display("FAIL reset_in_wait: got %h expected %h", obs, 22'h0);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    tick();
    obs = outs();
    n_total++;
    if (obs !== '0) $display("FAIL reset_release_quiet: got %h expected %h", obs, 22'h0);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_manual();
    test_timeout();
    test_coincide();
    test_auto();
    test_ignored();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
